// File: rtl/exec2.sv
// rtl/exec2.sv - KCP53K execute stage: OR-combined ALU, RV64 word mode, iterative shift-add multiplier.
// Registers the result as addr_o and forwards store data/control; stall_o holds decode during a multiply.
module exec2 #(
   parameter int XLEN = 64
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic [XLEN-1:0] inpa_i,
   input  logic [XLEN-1:0] inpb_i,
   input  logic            invB_i,
   input  logic            cflag_i,
   input  logic            lsh_en_i,
   input  logic            rsh_en_i,
   input  logic            ltu_en_i,
   input  logic            lts_en_i,
   input  logic            sum_en_i,
   input  logic            and_en_i,
   input  logic            xor_en_i,
   input  logic            mul_en_i,
   input  logic            word_i,
   input  logic [4:0]      rd_i,
   input  logic            we_i,
   input  logic            nomem_i,
   input  logic            mem_i,
   input  logic [XLEN-1:0] dat_i,
   input  logic [2:0]      xrs_rwe_i,
   input  logic            busy_i,
   output logic [4:0]      rd_o,
   output logic [XLEN-1:0] addr_o,
   output logic            we_o,
   output logic            nomem_o,
   output logic            mem_o,
   output logic [XLEN-1:0] dat_o,
   output logic [2:0]      xrs_rwe_o,
   output logic            stall_o
);
   localparam int SHW = $clog2(XLEN);
   localparam int CW  = $clog2(XLEN + 1);

   typedef enum logic {S_IDLE, S_MUL} state_t;
   state_t state, state_nx;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   logic            word;
   logic [SHW-1:0]  sh;
   logic [4:0]      sh5;
   logic [XLEN-1:0] b_eff, sum_r, rsh_f, res_full, res;
   logic [31:0]     a32, b32, be32, rsh_w, res_w;

   assign word = (XLEN == 64) && word_i;
   assign sh   = inpb_i[SHW-1:0];
   assign sh5  = inpb_i[4:0];
   assign a32  = inpa_i[31:0];
   assign b32  = inpb_i[31:0];

   always_comb begin
      b_eff = invB_i ? ~inpb_i : inpb_i;
      be32  = b_eff[31:0];
      sum_r = inpa_i + b_eff + XLEN'(cflag_i);
      // Arithmetic and logical shifts kept in separate statements so the signed operand is not coerced unsigned.
      if (cflag_i) rsh_f = $signed(inpa_i) >>> sh;
      else         rsh_f = inpa_i >> sh;
      if (cflag_i) rsh_w = $signed(a32) >>> sh5;
      else         rsh_w = a32 >> sh5;
      res_full = ({XLEN{lsh_en_i}} & (inpa_i << sh))
               | ({XLEN{rsh_en_i}} & rsh_f)
               | XLEN'(ltu_en_i & (inpa_i < inpb_i))
               | XLEN'(lts_en_i & ($signed(inpa_i) < $signed(inpb_i)))
               | ({XLEN{sum_en_i}} & sum_r)
               | ({XLEN{and_en_i}} & (inpa_i & b_eff))
               | ({XLEN{xor_en_i}} & (inpa_i ^ b_eff));
      res_w = ({32{lsh_en_i}} & (a32 << sh5))
            | ({32{rsh_en_i}} & rsh_w)
            | 32'(ltu_en_i & (a32 < b32))
            | 32'(lts_en_i & ($signed(a32) < $signed(b32)))
            | ({32{sum_en_i}} & sum_r[31:0])
            | ({32{and_en_i}} & (a32 & be32))
            | ({32{xor_en_i}} & (a32 ^ be32));
      res = word ? sext32(res_w) : res_full;
   end

   logic [XLEN-1:0] mcand, mplier, acc, acc_nx, mul_res, dat_h;
   logic [CW-1:0]   cnt;
   logic [4:0]      rd_h;
   logic [2:0]      xrs_h;
   logic            we_h, nomem_h, mem_h, word_h, mul_done;

   assign acc_nx   = mplier[0] ? acc + mcand : acc;
   assign mul_res  = word_h ? sext32(acc_nx[31:0]) : acc_nx;
   assign mul_done = (state == S_MUL) && (cnt == CW'(1));
   assign stall_o  = (state == S_MUL);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (!busy_i && mul_en_i) state_nx = S_MUL;
         S_MUL:   if (!busy_i && mul_done) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state <= S_IDLE;
      else         state <= state_nx;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_o <= '0; addr_o <= '0; we_o <= 1'b0; nomem_o <= 1'b0; mem_o <= 1'b0;
         dat_o <= '0; xrs_rwe_o <= '0;
         mcand <= '0; mplier <= '0; acc <= '0; cnt <= '0;
         rd_h <= '0; we_h <= 1'b0; nomem_h <= 1'b0; mem_h <= 1'b0;
         dat_h <= '0; xrs_h <= '0; word_h <= 1'b0;
      end else if (!busy_i) begin
         if (state == S_MUL) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (mul_done) begin
               addr_o <= mul_res; dat_o <= dat_h; rd_o <= rd_h; we_o <= we_h;
               nomem_o <= nomem_h; mem_o <= mem_h; xrs_rwe_o <= xrs_h;
            end else begin
               rd_o <= '0; we_o <= 1'b0; nomem_o <= 1'b0; mem_o <= 1'b0; xrs_rwe_o <= '0;
            end
         end else if (mul_en_i) begin
            mcand <= inpa_i; mplier <= inpb_i; acc <= '0;
            cnt <= word ? CW'(32) : CW'(XLEN);
            rd_h <= rd_i; we_h <= we_i; nomem_h <= nomem_i; mem_h <= mem_i;
            dat_h <= dat_i; xrs_h <= xrs_rwe_i; word_h <= word;
            // The accept edge itself emits a bubble so the previous instruction is not repeated.
            rd_o <= '0; we_o <= 1'b0; nomem_o <= 1'b0; mem_o <= 1'b0; xrs_rwe_o <= '0;
         end else begin
            addr_o <= res; dat_o <= dat_i; rd_o <= rd_i; we_o <= we_i;
            nomem_o <= nomem_i; mem_o <= mem_i; xrs_rwe_o <= xrs_rwe_i;
         end
      end
   end
endmodule

// File: tb/tb_exec2.sv
// tb/tb_exec2.sv - directed self-checking bench for exec2 (XLEN=64 and XLEN=32 builds).
module tb_exec2;
   logic clk = 1'b0;
   logic rst;
   logic [63:0] a, b, dat;
   logic invb, cflag, lsh, rsh, ltu, lts, sum, andf, xorf, mul, word;
   logic [4:0] rd;
   logic we, nomem, mem, busy;
   logic [2:0] xrs;
   logic [4:0] rd_o;
   logic [63:0] addr_o, dat_o;
   logic we_o, nomem_o, mem_o, stall_o;
   logic [2:0] xrs_o;

   logic [31:0] a32, b32;
   logic mul32, busy32;
   logic [4:0] rd32_o;
   logic [31:0] addr32_o, dat32_o;
   logic we32_o, nomem32_o, mem32_o, stall32_o;
   logic [2:0] xrs32_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   exec2 #(.XLEN(64)) dut (
      .clk_i(clk), .reset_i(rst), .inpa_i(a), .inpb_i(b), .invB_i(invb), .cflag_i(cflag),
      .lsh_en_i(lsh), .rsh_en_i(rsh), .ltu_en_i(ltu), .lts_en_i(lts), .sum_en_i(sum),
      .and_en_i(andf), .xor_en_i(xorf), .mul_en_i(mul), .word_i(word), .rd_i(rd),
      .we_i(we), .nomem_i(nomem), .mem_i(mem), .dat_i(dat), .xrs_rwe_i(xrs), .busy_i(busy),
      .rd_o(rd_o), .addr_o(addr_o), .we_o(we_o), .nomem_o(nomem_o), .mem_o(mem_o),
      .dat_o(dat_o), .xrs_rwe_o(xrs_o), .stall_o(stall_o)
   );

   exec2 #(.XLEN(32)) dut32 (
      .clk_i(clk), .reset_i(rst), .inpa_i(a32), .inpb_i(b32), .invB_i(invb), .cflag_i(cflag),
      .lsh_en_i(lsh), .rsh_en_i(rsh), .ltu_en_i(ltu), .lts_en_i(lts), .sum_en_i(sum),
      .and_en_i(andf), .xor_en_i(xorf), .mul_en_i(mul32), .word_i(word), .rd_i(rd),
      .we_i(we), .nomem_i(nomem), .mem_i(mem), .dat_i(dat[31:0]), .xrs_rwe_i(xrs), .busy_i(busy32),
      .rd_o(rd32_o), .addr_o(addr32_o), .we_o(we32_o), .nomem_o(nomem32_o), .mem_o(mem32_o),
      .dat_o(dat32_o), .xrs_rwe_o(xrs32_o), .stall_o(stall32_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a = '0; b = '0; dat = '0; invb = 0; cflag = 0; lsh = 0; rsh = 0; ltu = 0; lts = 0;
      sum = 0; andf = 0; xorf = 0; mul = 0; word = 0; rd = '0; we = 0; nomem = 0; mem = 0;
      xrs = '0; busy = 0; a32 = '0; b32 = '0; mul32 = 0; busy32 = 0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1;
      #2;
      tests++;
      if (addr_o !== 64'd0 || rd_o !== 5'd0 || we_o !== 1'b0 || stall_o !== 1'b0 || dat_o !== 64'd0) begin
         fails++;
         $display("FAIL reset: addr=%h rd=%0d we=%b stall=%b dat=%h required all zero", addr_o, rd_o, we_o, stall_o, dat_o);
      end
      tick();
      rst = 0;
   endtask

   task automatic test_add();
      idle(); a = 64'd5; b = 64'd3; sum = 1; rd = 5'd3; we = 1; dat = 64'hAB; xrs = 3'd2; mem = 1;
      tick();
      tests++;
      if (addr_o !== 64'd8 || rd_o !== 5'd3 || we_o !== 1'b1 || dat_o !== 64'hAB || xrs_o !== 3'd2 || mem_o !== 1'b1) begin
         fails++;
         $display("FAIL add: addr=%h rd=%0d we=%b dat=%h xrs=%0d mem=%b required 8/3/1/ab/2/1", addr_o, rd_o, we_o, dat_o, xrs_o, mem_o);
      end
      invb = 1; cflag = 1;
      tick();
      tests++;
      if (addr_o !== 64'd2) begin fails++; $display("FAIL sub5_3: addr=%h required 2", addr_o); end
      a = 64'd0; b = 64'd1;
      tick();
      tests++;
      if (addr_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL sub0_1: addr=%h required ffffffffffffffff", addr_o); end
      idle(); a = 64'hF0; b = 64'h0F; andf = 1; xorf = 1;
      tick();
      tests++;
      if (addr_o !== 64'hFF) begin fails++; $display("FAIL and_xor_or: addr=%h required ff", addr_o); end
   endtask

   task automatic test_shift();
      idle(); a = 64'h8000_0000_0000_0000; b = 64'd4; rsh = 1; cflag = 1;
      tick();
      tests++;
      if (addr_o !== 64'hF800_0000_0000_0000) begin fails++; $display("FAIL sra: addr=%h required f800000000000000", addr_o); end
      cflag = 0;
      tick();
      tests++;
      if (addr_o !== 64'h0800_0000_0000_0000) begin fails++; $display("FAIL srl: addr=%h required 0800000000000000", addr_o); end
      b = 64'd65;
      tick();
      tests++;
      if (addr_o !== 64'h4000_0000_0000_0000) begin fails++; $display("FAIL srl65: addr=%h required 4000000000000000", addr_o); end
      idle(); a = 64'd1; b = 64'd65; lsh = 1;
      tick();
      tests++;
      if (addr_o !== 64'd2) begin fails++; $display("FAIL sll65: addr=%h required 2", addr_o); end
   endtask

   task automatic test_word();
      idle(); a = 64'h7FFF_FFFF; b = 64'd1; sum = 1; word = 1;
      tick();
      tests++;
      if (addr_o !== 64'hFFFF_FFFF_8000_0000) begin fails++; $display("FAIL addw: addr=%h required ffffffff80000000", addr_o); end
      idle(); a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd0; lts = 1; word = 1;
      tick();
      tests++;
      if (addr_o !== 64'd1) begin fails++; $display("FAIL ltsw: addr=%h required 1", addr_o); end
      idle(); a = 64'h8000_0000; b = 64'd4; rsh = 1; cflag = 1; word = 1;
      tick();
      tests++;
      if (addr_o !== 64'hFFFF_FFFF_F800_0000) begin fails++; $display("FAIL sraw: addr=%h required fffffffff8000000", addr_o); end
      idle(); a = 64'd1; b = 64'd33; lsh = 1; word = 1;
      tick();
      tests++;
      if (addr_o !== 64'd2) begin fails++; $display("FAIL sllw33: addr=%h required 2", addr_o); end
   endtask

   task automatic test_mul();
      int bad;
      idle(); a = 64'd7; b = 64'd6; mul = 1; rd = 5'd9; we = 1; dat = 64'h55; xrs = 3'd5;
      tick();
      idle(); a = 64'd1; b = 64'd1; sum = 1; rd = 5'd4; we = 1; dat = 64'h99;
      bad = 0;
      for (int i = 1; i < 64; i++) begin
         if (stall_o !== 1'b1 || we_o !== 1'b0 || rd_o !== 5'd0) bad++;
         tick();
      end
      tests++;
      if (stall_o !== 1'b1 || bad != 0) begin fails++; $display("FAIL mul_bubbles: %0d bad bubble cycles, stall=%b required 0 bad and stall 1", bad, stall_o); end
      idle(); a = 64'd3; b = 64'd5; mul = 1; rd = 5'd2; we = 1;
      tick();
      tests++;
      if (stall_o !== 1'b0 || addr_o !== 64'd42 || rd_o !== 5'd9 || we_o !== 1'b1 || dat_o !== 64'h55 || xrs_o !== 3'd5) begin
         fails++;
         $display("FAIL mul7x6: stall=%b addr=%h rd=%0d we=%b dat=%h xrs=%0d required 0/2a/9/1/55/5", stall_o, addr_o, rd_o, we_o, dat_o, xrs_o);
      end
      tick();
      idle();
      tests++;
      if (stall_o !== 1'b1 || we_o !== 1'b0) begin fails++; $display("FAIL mul_b2b_start: stall=%b we=%b required 1/0", stall_o, we_o); end
      for (int i = 1; i < 64; i++) tick();
      tick();
      tests++;
      if (stall_o !== 1'b0 || addr_o !== 64'd15 || rd_o !== 5'd2) begin fails++; $display("FAIL mul3x5: stall=%b addr=%h rd=%0d required 0/f/2", stall_o, addr_o, rd_o); end
   endtask

   task automatic test_mul_word();
      idle(); a = 64'h10000; b = 64'h10000; mul = 1; word = 1; we = 1;
      tick();
      idle();
      for (int i = 1; i < 32; i++) tick();
      tests++;
      if (stall_o !== 1'b1) begin fails++; $display("FAIL mulw_len: stall=%b at edge 31 required 1", stall_o); end
      tick();
      tests++;
      if (stall_o !== 1'b0 || addr_o !== 64'd0 || we_o !== 1'b1) begin fails++; $display("FAIL mulw0: stall=%b addr=%h we=%b required 0/0/1", stall_o, addr_o, we_o); end
      a = 64'h0000_0001_0000_FFFF; b = 64'h10001; mul = 1; word = 1;
      tick();
      idle();
      for (int i = 0; i < 32; i++) tick();
      tests++;
      if (stall_o !== 1'b0 || addr_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL mulw_sext: stall=%b addr=%h required 0/ffffffffffffffff", stall_o, addr_o); end
   endtask

   task automatic test_mul32();
      idle(); a32 = 32'hFFFF_FFFF; b32 = 32'd2; mul32 = 1; we = 1; rd = 5'd7;
      tick();
      idle();
      for (int i = 1; i < 32; i++) tick();
      tests++;
      if (stall32_o !== 1'b1 || we32_o !== 1'b0) begin fails++; $display("FAIL mul32_len: stall=%b we=%b at edge 31 required 1/0", stall32_o, we32_o); end
      tick();
      tests++;
      if (stall32_o !== 1'b0 || addr32_o !== 32'hFFFF_FFFE || rd32_o !== 5'd7) begin
         fails++;
         $display("FAIL mul32: stall=%b addr=%h rd=%0d required 0/fffffffe/7", stall32_o, addr32_o, rd32_o);
      end
   endtask

   task automatic test_back_pressure();
      idle(); a = 64'd5; b = 64'd3; sum = 1; rd = 5'd6; we = 1;
      tick();
      busy = 1; a = 64'd100; b = 64'd1; rd = 5'd1; we = 0;
      tick(); tick(); tick();
      tests++;
      if (addr_o !== 64'd8 || rd_o !== 5'd6 || we_o !== 1'b1) begin fails++; $display("FAIL busy_hold: addr=%h rd=%0d we=%b required 8/6/1", addr_o, rd_o, we_o); end
      busy = 0;
      tick();
      tests++;
      if (addr_o !== 64'd101 || rd_o !== 5'd1) begin fails++; $display("FAIL busy_release: addr=%h rd=%0d required 65/1", addr_o, rd_o); end
      idle(); a = 64'd7; b = 64'd6; mul = 1; rd = 5'd9; we = 1;
      tick();
      idle();
      for (int i = 0; i < 10; i++) tick();
      busy = 1;
      for (int i = 0; i < 5; i++) tick();
      busy = 0;
      for (int i = 0; i < 53; i++) tick();
      tests++;
      if (stall_o !== 1'b1) begin fails++; $display("FAIL busy_mul_len: stall=%b one edge before delayed result required 1", stall_o); end
      tick();
      tests++;
      if (stall_o !== 1'b0 || addr_o !== 64'd42 || rd_o !== 5'd9) begin fails++; $display("FAIL busy_mul: stall=%b addr=%h rd=%0d required 0/2a/9", stall_o, addr_o, rd_o); end
   endtask

   task automatic test_reset_mid_mul();
      int bad;
      idle(); a = 64'd5; b = 64'd3; sum = 1; rd = 5'd6; we = 1;
      tick();
      idle(); a = 64'd7; b = 64'd6; mul = 1; rd = 5'd9; we = 1;
      tick();
      idle();
      for (int i = 0; i < 44; i++) tick();
      #2;
      rst = 1;
      #1;
      tests++;
      if (stall_o !== 1'b0 || addr_o !== 64'd0 || rd_o !== 5'd0 || we_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_mul: stall=%b addr=%h rd=%0d we=%b required all zero", stall_o, addr_o, rd_o, we_o);
      end
      #2;
      rst = 0;
      bad = 0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (we_o !== 1'b0 || addr_o !== 64'd0 || stall_o !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin fails++; $display("FAIL reset_no_result: %0d cycles with output activity required 0", bad); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_shift();
      test_word();
      test_mul();
      test_mul_word();
      test_mul32();
      test_back_pressure();
      test_reset_mid_mul();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/exec2.md
# exec2

Parametrised second-generation execute stage for the KCP53K pipeline. It sits between decode and memory. It registers the combined ALU result as the effective address or writeback value, and forwards the store data and control bits downstream. Relative to the first-generation stage it adds an `XLEN` parameter, an RV64 word mode (`*W` ops), arithmetic right shift, and an iterative multi-cycle multiplier that back-pressures decode through `stall_o`.

## Interface
- `XLEN`, 64, datapath width; legal values are 32 and 64.
- `SHW`, derived `$clog2(XLEN)`, shift-amount width; not overridable.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `inpa_i`, `inpb_i`  in  XLEN  operands A and B.
- `invB_i`  in  1  invert B before the adder and logic units.
- `cflag_i`  in  1  adder carry-in; also selects arithmetic right shift.
- `lsh_en_i`, `rsh_en_i`, `ltu_en_i`, `lts_en_i`, `sum_en_i`, `and_en_i`, `xor_en_i`  in  1 each  function-unit enables; results are OR-combined.
- `mul_en_i`  in  1  start a multiply; overrides all other enables.
- `word_i`  in  1  32-bit word mode; ignored when `XLEN`=32.
- `rd_i`  in  5  destination register.
- `we_i`, `nomem_i`, `mem_i`  in  1 each  memory/writeback control.
- `dat_i`  in  XLEN  store data.
- `xrs_rwe_i`  in  3  transfer size / sign-extend code.
- `busy_i`  in  1  memory stage stall; freezes this stage.
- `rd_o`  out  5; `addr_o`  out  XLEN (result); `we_o`, `nomem_o`, `mem_o`  out  1 each; `dat_o`  out  XLEN; `xrs_rwe_o`  out  3.
- `stall_o`  out  1  multiplier active; decode must hold its inputs.

## Operation
- An input is accepted on an edge where `busy_i`=0 and `stall_o`=0.
- On a non-multiply accept, all outputs load on that edge:
  - `addr_o` = OR of the enabled unit results.
  - Other outputs take their `_i` values.
- Effective B = `invB_i` ? ~`inpb_i` : `inpb_i`.
- sum = A + B + `cflag_i`, truncated to XLEN bits.
- ltu: 1 if A <u `inpb_i`; lts: 1 if A <s `inpb_i`. Both use the raw B operand and are zero-extended.
- lsh: A << B[SHW-1:0].
- rsh: A >> B[SHW-1:0]; arithmetic when `cflag_i`=1, logical otherwise.
- Word mode (XLEN=64, `word_i`=1):
  - Operands are the low 32 bits; shift amount is B[4:0].
  - The 32-bit result is sign-extended from bit 31 into `addr_o`.
- Multiply, low XLEN bits of the product, unsigned shift-add:
  - On accept, load mcand=A, mplier=B, acc=0, cnt=XLEN (32 in word mode).
  - `stall_o` goes 1 from that edge.
  - Each subsequent edge with `busy_i`=0: if mplier[0] then acc += mcand; mcand <<= 1; mplier >>= 1; cnt -= 1.
  - On the edge where cnt reaches 0: outputs load acc (sign-extended from bit 31 in word mode) plus the held control inputs, and `stall_o` drops.
  - Latency is fixed regardless of operand values; B=0 still takes the full count.
- While `stall_o`=1 and `busy_i`=0 and the multiply is not completing, outputs load a bubble each edge:
  - `we_o`=`nomem_o`=`mem_o`=0, `xrs_rwe_o`=0, `rd_o`=0.
  - `addr_o`/`dat_o` hold their values.
- `busy_i`=1 holds all outputs and all multiplier state unchanged.
- Priority: reset > `busy_i` > multiplier iteration > accept.

## Timing
- Reset (async, immediate): all outputs 0, `stall_o`=0, cnt=0, multiplier registers 0.
- A reset mid-multiply aborts it; no result is ever emitted.
- ALU op latency: 1 cycle; result visible after the accept edge.
- Multiply: `stall_o` high for exactly XLEN edges (32 in word mode) with `busy_i`=0. The result appears on the XLEN-th edge after accept.
  - Each `busy_i`=1 cycle extends the multiply by one cycle.
- The cycle `stall_o` falls, a new input may be accepted on the next edge; back-to-back multiplies are allowed.
- Inputs are sampled only on accept edges. Decode changes during stall are ignored, except that the control fields and `dat_i` are captured at accept.
- Simultaneous non-mul enables are OR-combined, not an error.

## Test plan
- Reset: assert `reset_i` mid-multiply (cnt=20) → `stall_o`=0 and all outputs 0 immediately; no result after release.
- Add/sub, XLEN=64:
  - A=5, B=3, `sum_en_i` → `addr_o`=8 one edge later.
  - Same operands with `invB_i`=1, `cflag_i`=1 → 2.
  - A=0, B=1, sub → 0xFFFF_FFFF_FFFF_FFFF.
- Shifts:
  - A=0x8000_0000_0000_0000, B=4, `rsh_en_i`, `cflag_i`=1 → 0xF800_0000_0000_0000; `cflag_i`=0 → 0x0800_0000_0000_0000.
  - B=65 → shift by 1.
- Word mode: A=0x7FFF_FFFF, B=1, `sum_en_i`, `word_i` → 0xFFFF_FFFF_8000_0000. `lts`: A=−1, B=0 → 1.
- Multiply:
  - A=7, B=6, `mul_en_i`, `rd_i`=9, `we_i`=1 → `stall_o` high 64 edges with bubbles (`we_o`=0), then `addr_o`=42, `rd_o`=9, `we_o`=1.
  - Word: A=0x10000, B=0x10000 → 0 after 32 edges.
  - XLEN=32 build: 0xFFFF_FFFF × 2 → 0xFFFF_FFFE after 32 edges.
- Backpressure: `busy_i`=1 for 3 cycles after an add → outputs unchanged. `busy_i`=1 for 5 cycles mid-multiply → result delayed exactly 5 cycles, value unchanged.
